// File: rtl/dest_reg_scoreboard_if.sv
// ID-stage request and scoreboard response bundle for dest_reg_scoreboard.
// The master drives the decoded ID instruction; the slave returns stall, forwarding and WB controls.
interface dest_reg_scoreboard_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [1:0]       id_regdst;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;

  logic             stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [REG_W-1:0] ex_dest;
  logic [REG_W-1:0] mem_dest;
  logic [REG_W-1:0] wb_dest;
  logic             wb_we;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_regdst, id_regwrite, id_memread, flush,
    input  stall, fwd_a, fwd_b, ex_dest, mem_dest, wb_dest, wb_we
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_regdst, id_regwrite, id_memread, flush,
    output stall, fwd_a, fwd_b, ex_dest, mem_dest, wb_dest, wb_we
  );
endinterface

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard for a five-stage core: load-use stall, EX forwarding, WB write port.
// Optional macro SCOREBOARD_STATS_EN adds the saturating stall_cnt output.
module dest_reg_scoreboard #(
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dest_reg_scoreboard_if.slave   bus
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt
`endif
);

  localparam logic [REG_W-1:0] LINK_ADDR = REG_W'(LINK_REG);

  // ID resolve
  logic [REG_W-1:0]       id_dest;
  logic                   id_we;
  logic [1:0][REG_W-1:0]  id_src;
  logic [1:0]             id_uses;

  // EX stage
  logic                   ex_valid_q, ex_valid_d;
  logic                   ex_we_q, ex_we_d;
  logic                   ex_load_q, ex_load_d;
  logic [REG_W-1:0]       ex_dest_q, ex_dest_d;
  logic [1:0][REG_W-1:0]  ex_src_q, ex_src_d;
  logic [1:0]             ex_uses_q, ex_uses_d;

  // MEM and WB stages
  logic                   mem_valid_q, mem_we_q, mem_load_q;
  logic [REG_W-1:0]       mem_dest_q;
  logic                   wb_valid_q, wb_we_q;
  logic [REG_W-1:0]       wb_dest_q;

  logic [1:0]             src_hit;
  logic [1:0][1:0]        fwd_sel;
  logic                   stall_w;
  logic                   ex_take;
  logic                   mem_fwd_ok;
  logic                   wb_fwd_ok;

  always_comb begin
    id_dest = '0;
    unique case (bus.id_regdst)
      2'b00:   id_dest = bus.id_rt;
      2'b01:   id_dest = bus.id_rd;
      2'b10:   id_dest = LINK_ADDR;
      default: id_dest = '0;
    endcase
  end

  assign id_we   = bus.id_valid & bus.id_regwrite & (bus.id_regdst != 2'b11) & (id_dest != '0);
  assign id_src  = {bus.id_rt, bus.id_rs};
  assign id_uses = {bus.id_uses_rt, bus.id_uses_rs};

  // Index 0 is operand A (rs), index 1 is operand B (rt).
  // A load sitting in MEM is excluded as a source; the load-use stall makes WB supply it instead.
  assign mem_fwd_ok = mem_valid_q & mem_we_q & ~mem_load_q;
  assign wb_fwd_ok  = wb_valid_q & wb_we_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign src_hit[gi] = id_uses[gi] & (id_src[gi] == ex_dest_q);
    assign fwd_sel[gi] = (ex_uses_q[gi] & mem_fwd_ok & (mem_dest_q == ex_src_q[gi])) ? 2'b10 :
                         (ex_uses_q[gi] & wb_fwd_ok  & (wb_dest_q  == ex_src_q[gi])) ? 2'b01 :
                                                                                     2'b00;
  end

  assign stall_w = bus.id_valid & ex_valid_q & ex_load_q & ex_we_q & (|src_hit);
  assign ex_take = bus.id_valid & ~stall_w & ~bus.flush;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_we_d    = 1'b0;
    ex_load_d  = 1'b0;
    ex_dest_d  = '0;
    ex_src_d   = '0;
    ex_uses_d  = '0;
    if (ex_take) begin
      ex_valid_d = 1'b1;
      ex_we_d    = id_we;
      ex_load_d  = bus.id_memread;
      ex_dest_d  = id_dest;
      ex_src_d   = id_src;
      ex_uses_d  = id_uses;
    end
  end

  // EX/MEM/WB always advance; a stall only injects a bubble into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_dest_q   <= '0;
      ex_src_q    <= '0;
      ex_uses_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_load_q  <= 1'b0;
      mem_dest_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_dest_q   <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_we_q     <= ex_we_d;
      ex_load_q   <= ex_load_d;
      ex_dest_q   <= ex_dest_d;
      ex_src_q    <= ex_src_d;
      ex_uses_q   <= ex_uses_d;
      mem_valid_q <= ex_valid_q;
      mem_we_q    <= ex_we_q;
      mem_load_q  <= ex_load_q;
      mem_dest_q  <= ex_dest_q;
      wb_valid_q  <= mem_valid_q;
      wb_we_q     <= mem_we_q;
      wb_dest_q   <= mem_dest_q;
    end
  end

  assign bus.stall    = stall_w;
  assign bus.fwd_a    = fwd_sel[0];
  assign bus.fwd_b    = fwd_sel[1];
  assign bus.ex_dest  = ex_dest_q;
  assign bus.mem_dest = mem_dest_q;
  assign bus.wb_dest  = wb_dest_q;
  assign bus.wb_we    = wb_valid_q & wb_we_q;

`ifdef SCOREBOARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_w && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
